// File: rtl/alu_exec_unit_if.sv
// Operand/result bus between the EX-stage control path and the ALU datapath.
// The master drives operands and start; the slave returns handshake and result.
interface alu_exec_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       ALU_ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output start, ALU_ctrl, a, b,
        input  busy, done, result, zero, illegal
    );

    modport slave (
        input  start, ALU_ctrl, a, b,
        output busy, done, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Sequential ALU for the EX stage. Single-cycle ops finish on the capture edge.
// mul is an unsigned shift-add over WIDTH cycles, keeping only the low WIDTH bits.
module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mcand;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] acc_next;

    // Single-cycle result from the live operands, used only on an accepted start
    always_comb begin
        op_res = '0;
        case (bus.ALU_ctrl)
            3'b000:  op_res = bus.a + bus.b;
            3'b001:  op_res = bus.a - bus.b;
            3'b010:  op_res = bus.a & bus.b;
            3'b011:  op_res = bus.a | bus.b;
            3'b100:  op_res = bus.a << bus.b[SHW-1:0];
            default: op_res = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplier when the multiplicand LSB is set
    always_comb begin
        acc_next = mcand[0] ? acc + mplier : acc;
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.result  <= '0;
            bus.zero    <= 1'b0;
            bus.illegal <= 1'b0;
            acc         <= '0;
            mplier      <= '0;
            mcand       <= '0;
            cnt         <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.ALU_ctrl == 3'b101) begin
                            mplier   <= bus.a;
                            mcand    <= bus.b;
                            acc      <= '0;
                            cnt      <= '0;
                            bus.busy <= 1'b1;
                            state    <= MUL;
                        end else begin
                            bus.result  <= op_res;
                            bus.zero    <= (op_res == '0);
                            bus.illegal <= bus.ALU_ctrl[2] & bus.ALU_ctrl[1];
                            bus.done    <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mplier <= mplier << 1;
                    mcand  <= mcand >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH - 1)) begin
                        bus.result  <= acc_next;
                        bus.zero    <= (acc_next == '0);
                        bus.illegal <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, random ops
// against an arithmetic reference model, and hand-written handshake/reset sequences.
module tb_alu_exec_unit;
    localparam int WIDTH = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctrl;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        zero;
        logic        ill;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the operation, returns {illegal, result}
    function automatic logic [16:0] model(input logic [2:0] c, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        logic [31:0] s;
        p = {16'h0, x} * {16'h0, y};
        s = {16'h0, x} << y[3:0];
        case (c)
            3'd0:    return {1'b0, 16'(x + y)};
            3'd1:    return {1'b0, 16'(x - y)};
            3'd2:    return {1'b0, x & y};
            3'd3:    return {1'b0, x | y};
            3'd4:    return {1'b0, s[15:0]};
            3'd5:    return {1'b0, p[15:0]};
            default: return {1'b1, 16'h0000};
        endcase
    endfunction

    // Launch one op, scramble inputs after capture, wait for done and check it
    task automatic run_op(input string name, input logic [2:0] c, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] er, input logic ez,
                          input logic ei);
        int lat;
        int busy_cycles;
        bus.start    = 1'b1;
        bus.ALU_ctrl = c;
        bus.a        = x;
        bus.b        = y;
        tick();
        bus.start    = 1'b0;
        bus.ALU_ctrl = 3'($urandom);
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        lat          = 1;
        busy_cycles  = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cycles++;
            tick();
            lat++;
        end
        check({name, "_latency"}, lat, (c == 3'd5) ? 17 : 1);
        check({name, "_busy_cycles"}, busy_cycles, (c == 3'd5) ? 16 : 0);
        check({name, "_busy_at_done"}, int'(bus.busy), 0);
        check({name, "_result"}, int'(bus.result), int'(er));
        check({name, "_zero"}, int'(bus.zero), int'(ez));
        check({name, "_illegal"}, int'(bus.illegal), int'(ei));
    endtask

    initial begin
        logic [16:0] m;
        logic [2:0]  rc;
        logic [15:0] ra;
        logic [15:0] rb;
        int          lat;
        int          done_seen;

        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.ALU_ctrl = 3'd0;
        bus.a        = '0;
        bus.b        = '0;

        vecs[0]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        vecs[3]  = '{3'd5, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 1'b0};
        vecs[4]  = '{3'd5, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{3'd4, 16'h0001, 16'h001F, 16'h8000, 1'b0, 1'b0};
        vecs[6]  = '{3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
        vecs[7]  = '{3'd3, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 1'b0};
        vecs[8]  = '{3'd6, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b1};
        vecs[10] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{3'd5, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0};

        tick();
        tick();
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_result", int'(bus.result), 0);
        check("reset_zero", int'(bus.zero), 0);
        check("reset_illegal", int'(bus.illegal), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].zero, vecs[i].ill);
            tick();
            check($sformatf("vec%0d_done_drop", i), int'(bus.done), 0);
        end

        for (int i = 0; i < 40; i++) begin
            rc = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = 16'($urandom);
            m  = model(rc, ra, rb);
            run_op($sformatf("rnd%0d", i), rc, ra, rb, m[15:0], (m[15:0] == 16'h0), m[16]);
        end

        // Start pulsed mid-mul is ignored; start in the done cycle is accepted
        tick();
        bus.start    = 1'b1;
        bus.ALU_ctrl = 3'd5;
        bus.a        = 16'h0123;
        bus.b        = 16'h0045;
        tick();
        bus.start = 1'b0;
        lat       = 1;
        while (!bus.done && lat < 40) begin
            if (lat == 5) begin
                bus.start    = 1'b1;
                bus.ALU_ctrl = 3'd0;
                bus.a        = 16'h0001;
                bus.b        = 16'h0001;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            lat++;
        end
        check("t5_mul_latency", lat, 17);
        check("t5_mul_result", int'(bus.result), 16'h4E6F);
        bus.start    = 1'b1;
        bus.ALU_ctrl = 3'd0;
        bus.a        = 16'h0002;
        bus.b        = 16'h0003;
        tick();
        bus.start = 1'b0;
        check("t5_b2b_done", int'(bus.done), 1);
        check("t5_b2b_result", int'(bus.result), 5);
        tick();
        check("t5_b2b_done_drop", int'(bus.done), 0);

        // Reset during a mul aborts it with no done
        bus.start    = 1'b1;
        bus.ALU_ctrl = 3'd5;
        bus.a        = 16'h0123;
        bus.b        = 16'h0045;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        check("t6_busy_before_rst", int'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_busy", int'(bus.busy), 0);
        check("t6_rst_done", int'(bus.done), 0);
        check("t6_rst_result", int'(bus.result), 0);
        done_seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (bus.done) done_seen++;
            tick();
        end
        check("t6_no_done_after_abort", done_seen, 0);
        run_op("t6_illegal", 3'b110, 16'hABCD, 16'h1111, 16'h0000, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
